four_bit_greater_than: RTL and testbench

// - Unsigned magnitude comparator: agtb = 1 when a > b, else 0.
// - Result is registered (one flop stage), giving a clean timing boundary for downstream logic.
// - Gate-level datapath built from 2-bit compare slices. Leaf arithmetic block in the combinational-logic library.

---
 rtl/cmp_pkg.sv | 12 +
 rtl/four_bit_greater_than_if.sv | 20 ++
 rtl/two_bit_greater_than.sv | 20 ++
 rtl/four_bit_greater_than.sv | 67 ++++++
 tb/tb_four_bit_greater_than.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/cmp_pkg.sv
// Shared types for the magnitude-comparator slices: slice width and the
// per-slice {gt, eq} result carried through the MSB-first cascade.
package cmp_pkg;

    localparam int SLICE_W = 2;

    typedef struct packed {
        logic gt;
        logic eq;
    } cmp_res_t;

endpackage : cmp_pkg

// File: rtl/four_bit_greater_than_if.sv
// Operand/result bundle for the registered comparator.
// The aeqb result exists only when GT_AEQB_OUT_EN is defined.
interface four_bit_greater_than_if #(
    parameter int WIDTH = 4
) ();

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             agtb;
`ifdef GT_AEQB_OUT_EN
    logic             aeqb;

    modport master (output a, output b, input agtb, input aeqb);
    modport slave  (input a, input b, output agtb, output aeqb);
`else
    modport master (output a, output b, input agtb);
    modport slave  (input a, input b, output agtb);
`endif

endinterface : four_bit_greater_than_if

// File: rtl/two_bit_greater_than.sv
// Combinational 2-bit compare slice producing {gt, eq} from plain gates;
// the top level cascades these MSB-first.
module two_bit_greater_than
    import cmp_pkg::*;
(
    input  logic [SLICE_W-1:0] a_i,
    input  logic [SLICE_W-1:0] b_i,
    output cmp_res_t           res_o
);

    logic eq_hi;
    logic eq_lo;

    assign eq_hi = a_i[1] ~^ b_i[1];
    assign eq_lo = a_i[0] ~^ b_i[0];

    assign res_o.gt = (a_i[1] & ~b_i[1]) | (eq_hi & a_i[0] & ~b_i[0]);
    assign res_o.eq = eq_hi & eq_lo;

endmodule : two_bit_greater_than

// File: rtl/four_bit_greater_than.sv
// Registered unsigned comparator: agtb <= (a > b) one cycle after sampling.
// Define GT_AEQB_OUT_EN to also register and expose aeqb <= (a == b).
module four_bit_greater_than
    import cmp_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    four_bit_greater_than_if.slave  cmp_if
);

    localparam int NSLICE = WIDTH / SLICE_W;

    if (((WIDTH % SLICE_W) != 0) || (WIDTH < SLICE_W)) begin : g_bad_width
        $error("four_bit_greater_than: WIDTH must be even and at least 2");
    end

    cmp_res_t slice_res [NSLICE];
    cmp_res_t acc_d;
    logic     agtb_q;

    for (genvar i = 0; i < NSLICE; i++) begin : g_slice
        two_bit_greater_than u_slice (
            .a_i   (cmp_if.a[i*SLICE_W +: SLICE_W]),
            .b_i   (cmp_if.b[i*SLICE_W +: SLICE_W]),
            .res_o (slice_res[i])
        );
    end

    // Higher slice decides unless it is equal, in which case the lower one does.
    always_comb begin
        acc_d = slice_res[NSLICE-1];
        for (int i = NSLICE - 2; i >= 0; i--) begin
            acc_d.gt = acc_d.gt | (acc_d.eq & slice_res[i].gt);
            acc_d.eq = acc_d.eq & slice_res[i].eq;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            agtb_q <= 1'b0;
        end else begin
            agtb_q <= acc_d.gt;
        end
    end

    assign cmp_if.agtb = agtb_q;

`ifdef GT_AEQB_OUT_EN
    logic aeqb_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aeqb_q <= 1'b0;
        end else begin
            aeqb_q <= acc_d.eq;
        end
    end

    assign cmp_if.aeqb = aeqb_q;
`else
    logic unused_eq;
    assign unused_eq = acc_d.eq;
`endif

endmodule : four_bit_greater_than

// File: tb/tb_four_bit_greater_than.sv
// Scoreboard bench for four_bit_greater_than: reset, exhaustive sweep,
// corners and mid-run async reset. Honours GT_AEQB_OUT_EN.
module tb_four_bit_greater_than;

    typedef struct {
        logic       gt;
        logic       eq;
        logic [3:0] a;
        logic [3:0] b;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    int   gt_ones;
    int   eq_ones;
    exp_t sb_q[$];

    four_bit_greater_than_if #(.WIDTH(4)) cmp_if ();

    four_bit_greater_than #(.WIDTH(4)) u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .cmp_if (cmp_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic obs, input logic exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs == exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive at the falling edge and queue the golden result for the next rising edge.
    task automatic drive(input logic [3:0] a, input logic [3:0] b);
        exp_t e;
        @(negedge clk);
        cmp_if.a = a;
        cmp_if.b = b;
        e.gt = (a > b);
        e.eq = (a == b);
        e.a  = a;
        e.b  = b;
        sb_q.push_back(e);
    endtask

    task automatic sample(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check(tag, 1'b1, 1'b0);
        end else begin
            e = sb_q.pop_front();
            if (cmp_if.agtb === 1'b1) gt_ones++;
            check($sformatf("%s agtb a=%h b=%h", tag, e.a, e.b), cmp_if.agtb, e.gt);
`ifdef GT_AEQB_OUT_EN
            if (cmp_if.aeqb === 1'b1) eq_ones++;
            check($sformatf("%s aeqb a=%h b=%h", tag, e.a, e.b), cmp_if.aeqb, e.eq);
`endif
        end
    endtask

    initial begin
        logic [3:0] corner_a [5];
        logic [3:0] corner_b [5];
        n_checks = 0;
        n_pass   = 0;
        n_fail   = 0;
        corner_a = '{4'h0, 4'hF, 4'h8, 4'h7, 4'h5};
        corner_b = '{4'h0, 4'hF, 4'h7, 4'h8, 4'h4};

        // Reset held with a > b: output must stay clear.
        rst_n    = 1'b0;
        cmp_if.a = 4'hF;
        cmp_if.b = 4'h0;
        #1;
        check("reset_agtb_t0", cmp_if.agtb, 1'b0);
        repeat (3) begin
            @(posedge clk);
            #1;
            check("reset_agtb_held", cmp_if.agtb, 1'b0);
`ifdef GT_AEQB_OUT_EN
            check("reset_aeqb_held", cmp_if.aeqb, 1'b0);
`endif
        end
        @(negedge clk);
        rst_n = 1'b1;
        drive(4'hF, 4'h0);
        sample("release");

        // Exhaustive sweep, one pair per cycle.
        gt_ones = 0;
        eq_ones = 0;
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                drive(4'(ia), 4'(ib));
                sample("sweep");
            end
        end
        check_int("sweep_gt_count", gt_ones, 120);
`ifdef GT_AEQB_OUT_EN
        check_int("sweep_eq_count", eq_ones, 16);
`endif

        for (int i = 0; i < 5; i++) begin
            drive(corner_a[i], corner_b[i]);
            sample("corner");
        end

`ifdef GT_AEQB_OUT_EN
        drive(4'h6, 4'h6);
        sample("eq66");
        drive(4'h6, 4'h5);
        sample("eq65");
`endif

        // Async reset dropped between edges, then released.
        drive(4'h9, 4'h2);
        sample("pre_async");
        #2;
        rst_n = 1'b0;
        #1;
        check("async_clear", cmp_if.agtb, 1'b0);
`ifdef GT_AEQB_OUT_EN
        check("async_clear_eq", cmp_if.aeqb, 1'b0);
`endif
        @(negedge clk);
        check("async_still_clear", cmp_if.agtb, 1'b0);
        rst_n = 1'b1;
        drive(4'h9, 4'h2);
        sample("post_async");

        check_int("scoreboard_empty", sb_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_four_bit_greater_than
